// File: rtl/regfile_8x16.sv
// Eight-entry register file with one synchronous write port, a sequenced clear
// engine and a per-entry valid mask. Optional macro REGFILE_R0_ZERO_EN hard-wires entry 0.
module regfile_8x16 #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_req,
    output logic             busy,
    output logic             wr_drop,
    output logic [7:0]       valid,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q4,
    output logic [WIDTH-1:0] q5,
    output logic [WIDTH-1:0] q6,
    output logic [WIDTH-1:0] q7
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             drop_q, drop_d;
    logic [7:0]       valid_q, valid_d;
    logic [WIDTH-1:0] regs_q [8];
    logic [WIDTH-1:0] regs_d [8];
    logic             addr_ok;
    logic             wr_ok;

    // Writes aimed at a hard-wired entry 0 vanish entirely, including any drop pulse.
`ifdef REGFILE_R0_ZERO_EN
    assign addr_ok = (wr_addr != 3'd0);
`else
    assign addr_ok = 1'b1;
`endif

    assign wr_ok = wr_en && addr_ok && !busy_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = 3'd0;
                end
            end
            CLEAR: begin
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    state_d = IDLE;
                    idx_d   = 3'd0;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 3'd0;
            end
        endcase
        busy_d = (state_d == CLEAR);
        drop_d = wr_en && addr_ok && busy_q;
    end

    // A write and a sweep never hit the same edge: writes are dropped while busy.
    always_comb begin
        valid_d = valid_q;
        for (int n = 0; n < 8; n++) begin
            regs_d[n] = regs_q[n];
            if (wr_ok && (wr_addr == 3'(n))) begin
                regs_d[n]  = wr_data;
                valid_d[n] = 1'b1;
            end
            if ((state_q == CLEAR) && (idx_q == 3'(n))) begin
                regs_d[n]  = CLR_VAL;
                valid_d[n] = 1'b0;
            end
        end
`ifdef REGFILE_R0_ZERO_EN
        regs_d[0]  = CLR_VAL;
        valid_d[0] = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
            valid_q <= 8'h00;
            for (int n = 0; n < 8; n++) begin
                regs_q[n] <= CLR_VAL;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
            valid_q <= valid_d;
            for (int n = 0; n < 8; n++) begin
                regs_q[n] <= regs_d[n];
            end
        end
    end

    assign busy    = busy_q;
    assign wr_drop = drop_q;
    assign valid   = valid_q;
    assign q0      = regs_q[0];
    assign q1      = regs_q[1];
    assign q2      = regs_q[2];
    assign q3      = regs_q[3];
    assign q4      = regs_q[4];
    assign q5      = regs_q[5];
    assign q6      = regs_q[6];
    assign q7      = regs_q[7];

endmodule
